// File: rtl/efpga_lint_pkg.sv
// Shared types and constants for the APB-to-LINT initiator.
// Holds the FSM state encoding and the LINT idle/default field values.
package efpga_lint_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } lint_init_state_e;

  localparam logic        LINT_WEN_READ     = 1'b1;
  localparam logic [3:0]  LINT_BE_FULL      = 4'hF;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;

  // Reads always fetch the full word; writes honour the APB strobes.
  function automatic logic [3:0] capture_be(input logic pwrite, input logic [3:0] pstrb);
    logic [3:0] be;
    if (pwrite) begin
      be = pstrb;
    end else begin
      be = LINT_BE_FULL;
    end
    return be;
  endfunction

endpackage

// File: rtl/efpga_apb_lint_initiator_timeout_cnt.sv
// Saturating down-counter used to bound the REQ, WAIT and DRAIN phases.
// Expiry is flagged on the cycle the count reaches zero, so the phase lasts exactly TIMEOUT_CYCLES.
module lint_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             asic_clk_i,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge asic_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i & (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/efpga_apb_lint_initiator.sv
// APB slave to eFPGA LINT initiator: one LINT request per APB transfer, with a bounded
// timeout, an error response, and a drain phase that swallows a late orphaned r_valid.
module efpga_apb_lint_initiator
  import efpga_lint_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 20,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                      asic_clk_i,
  input  logic                      rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [31:0]               pwdata_i,
  input  logic [3:0]                pstrb_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic                      lint_req_o,
  input  logic                      lint_gnt_i,
  output logic [31:0]               lint_add_o,
  output logic                      lint_wen_o,
  output logic [3:0]                lint_be_o,
  output logic [31:0]               lint_wdata_o,
  input  logic                      lint_r_valid_i,
  input  logic [31:0]               lint_r_rdata_i,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

  lint_init_state_e state_q, state_d;
  logic        orphan_q,  orphan_d;
  logic        req_q,     req_d;
  logic [31:0] add_q,     add_d;
  logic        wen_q,     wen_d;
  logic [3:0]  be_q,      be_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [31:0] prdata_q,  prdata_d;
  logic        pready_q,  pready_d;
  logic        pslverr_q, pslverr_d;
  logic        busy_q,    busy_d;
  logic        tmo_q,     tmo_d;
  logic        capture_s;
  logic        cnt_load_s;
  logic        cnt_en_s;
  logic        expire_s;

  assign cnt_en_s   = (state_q == ST_REQ) | (state_q == ST_WAIT) | (state_q == ST_DRAIN);
  assign cnt_load_s = (state_d != state_q) &
                      ((state_d == ST_REQ) | (state_d == ST_WAIT) | (state_d == ST_DRAIN));

  lint_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout_cnt (
    .asic_clk_i (asic_clk_i),
    .rst_n      (rst_n),
    .load_i     (cnt_load_s),
    .en_i       (cnt_en_s),
    .load_val_i (CNT_LOAD),
    .expire_o   (expire_s)
  );

  // FSM next state and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    orphan_d  = orphan_q;
    req_d     = req_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    tmo_d     = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel_i && !penable_i) begin
          if (orphan_q) begin
            state_d = ST_DRAIN;
          end else begin
            capture_s = 1'b1;
            req_d     = 1'b1;
            state_d   = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A grant that lands on the expiry cycle is still honoured.
        if (lint_gnt_i) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end else if (expire_s) begin
          req_d     = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          tmo_d     = 1'b1;
          prdata_d  = (wen_q == LINT_WEN_READ) ? ERR_RDATA : 32'h0000_0000;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (lint_r_valid_i) begin
          pready_d = 1'b1;
          prdata_d = (wen_q == LINT_WEN_READ) ? lint_r_rdata_i : 32'h0000_0000;
          state_d  = ST_RESP;
        end else if (expire_s) begin
          orphan_d  = 1'b1;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          tmo_d     = 1'b1;
          prdata_d  = (wen_q == LINT_WEN_READ) ? ERR_RDATA : 32'h0000_0000;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        // The late response is dropped; the held APB access phase supplies the new fields.
        if (lint_r_valid_i || expire_s) begin
          orphan_d  = 1'b0;
          tmo_d     = ~lint_r_valid_i;
          capture_s = 1'b1;
          req_d     = 1'b1;
          state_d   = ST_REQ;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE) | orphan_d;
  end

  // Request fields are only sampled at the start of a LINT transaction.
  always_comb begin
    add_d   = add_q;
    wen_d   = wen_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    if (capture_s) begin
      add_d   = 32'(paddr_i);
      wen_d   = ~pwrite_i;
      be_d    = capture_be(pwrite_i, pstrb_i);
      wdata_d = pwdata_i;
    end else begin
      add_d   = add_q;
    end
  end

  // State and output registers.
  always_ff @(posedge asic_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      orphan_q  <= 1'b0;
      req_q     <= 1'b0;
      add_q     <= 32'h0000_0000;
      wen_q     <= LINT_WEN_READ;
      be_q      <= LINT_BE_FULL;
      wdata_q   <= 32'h0000_0000;
      prdata_q  <= 32'h0000_0000;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      orphan_q  <= orphan_d;
      req_q     <= req_d;
      add_q     <= add_d;
      wen_q     <= wen_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
    end
  end

  assign lint_req_o   = req_q;
  assign lint_add_o   = add_q;
  assign lint_wen_o   = wen_q;
  assign lint_be_o    = be_q;
  assign lint_wdata_o = wdata_q;
  assign prdata_o     = prdata_q;
  assign pready_o     = pready_q;
  assign pslverr_o    = pslverr_q;
  assign busy_o       = busy_q;
  assign timeout_o    = tmo_q;

endmodule

// File: tb/tb_efpga_apb_lint_initiator.sv
// Directed bench for efpga_apb_lint_initiator with TIMEOUT_CYCLES = 8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_efpga_apb_lint_initiator;

  localparam int unsigned AW = 20;
  localparam int unsigned TO = 8;
  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic [31:0]   prdata;
  logic          pready, pslverr;
  logic          req, gnt;
  logic [31:0]   add;
  logic          wen;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          busy, tmo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  efpga_apb_lint_initiator #(
    .APB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (ERR)
  ) dut (
    .asic_clk_i     (clk),
    .rst_n          (rst_n),
    .paddr_i        (paddr),
    .psel_i         (psel),
    .penable_i      (penable),
    .pwrite_i       (pwrite),
    .pwdata_i       (pwdata),
    .pstrb_i        (pstrb),
    .prdata_o       (prdata),
    .pready_o       (pready),
    .pslverr_o      (pslverr),
    .lint_req_o     (req),
    .lint_gnt_i     (gnt),
    .lint_add_o     (add),
    .lint_wen_o     (wen),
    .lint_be_o      (be),
    .lint_wdata_o   (wdata),
    .lint_r_valid_i (rvalid),
    .lint_r_rdata_i (rdata),
    .busy_o         (busy),
    .timeout_o      (tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = 32'h0; pstrb = 4'h0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    tick(); tick();

    // Reset values
    chk1 ("rst_req",     req,     1'b0);
    chk1 ("rst_wen",     wen,     1'b1);
    chk32("rst_be",      {28'h0, be}, 32'h0000_000F);
    chk32("rst_add",     add,     32'h0);
    chk32("rst_prdata",  prdata,  32'h0);
    chk1 ("rst_pready",  pready,  1'b0);
    chk1 ("rst_pslverr", pslverr, 1'b0);
    chk1 ("rst_busy",    busy,    1'b0);
    chk1 ("rst_tmo",     tmo,     1'b0);
    rst_n = 1'b1;
    tick();

    // Write, gnt immediate, r_valid next: pready at T3
    setup(1'b1, 20'h00040, 32'hA5A5_1234, 4'h3);
    tick();                                   // T1
    penable = 1'b1; gnt = 1'b1;
    chk1 ("w_req",   req,   1'b1);
    chk32("w_add",   add,   32'h0000_0040);
    chk1 ("w_wen",   wen,   1'b0);
    chk32("w_be",    {28'h0, be}, 32'h0000_0003);
    chk32("w_wdata", wdata, 32'hA5A5_1234);
    chk1 ("w_pready_t1", pready, 1'b0);
    tick();                                   // T2
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1111_2222;
    chk1 ("w_req_drop",  req,    1'b0);
    chk1 ("w_pready_t2", pready, 1'b0);
    tick();                                   // T3
    rvalid = 1'b0;
    chk1 ("w_pready_t3", pready,  1'b1);
    chk1 ("w_pslverr",   pslverr, 1'b0);
    chk32("w_prdata",    prdata,  32'h0);
    psel = 1'b0; penable = 1'b0;
    tick();                                   // T4
    chk1 ("w_pready_t4", pready, 1'b0);
    chk1 ("w_busy_t4",   busy,   1'b0);

    // Read, gnt after 5 cycles, r_valid 3 cycles after gnt
    setup(1'b0, 20'h01234, 32'hFFFF_FFFF, 4'h0);
    tick();                                   // T1
    penable = 1'b1;
    for (int i = 0; i < 6; i++) begin         // T1..T6
      chk1 ("r_req_held", req, 1'b1);
      chk32("r_add_held", add, 32'h0000_1234);
      chk1 ("r_wen_held", wen, 1'b1);
      chk32("r_be_held",  {28'h0, be}, 32'h0000_000F);
      if (i == 5) gnt = 1'b1;
      tick();
    end
    gnt = 1'b0;                               // T7
    chk1("r_req_drop", req, 1'b0);
    chk1("r_pready_t7", pready, 1'b0);
    tick();                                   // T8
    chk1("r_pready_t8", pready, 1'b0);
    tick();                                   // T9
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    chk1("r_pready_t9", pready, 1'b0);
    tick();                                   // T10
    rvalid = 1'b0;
    chk1 ("r_pready",  pready,  1'b1);
    chk32("r_prdata",  prdata,  32'hCAFE_F00D);
    chk1 ("r_pslverr", pslverr, 1'b0);
    psel = 1'b0; penable = 1'b0;
    tick();
    chk1 ("r_pready_after", pready, 1'b0);
    chk32("r_prdata_hold",  prdata, 32'hCAFE_F00D);

    // gnt never: req high for exactly 8 cycles, then error response
    setup(1'b0, 20'hFFFFF, 32'h0, 4'h0);
    tick();                                   // T1
    penable = 1'b1;
    for (int i = 0; i < 8; i++) begin         // T1..T8
      chk1("g_req_high", req, 1'b1);
      chk1("g_tmo_low",  tmo, 1'b0);
      tick();
    end
    chk1 ("g_req_drop", req,     1'b0);       // T9
    chk1 ("g_pready",   pready,  1'b1);
    chk1 ("g_pslverr",  pslverr, 1'b1);
    chk32("g_prdata",   prdata,  ERR);
    chk1 ("g_tmo",      tmo,     1'b1);
    chk32("g_add",      add,     32'h000F_FFFF);
    psel = 1'b0; penable = 1'b0;
    tick();                                   // T10
    chk1("g_tmo_once",    tmo,     1'b0);
    chk1("g_pready_once", pready,  1'b0);
    chk1("g_pslverr_clr", pslverr, 1'b0);
    chk1("g_busy_clr",    busy,    1'b0);

    // r_valid withheld past timeout; late r_valid drained during the next read
    setup(1'b0, 20'h00100, 32'h0, 4'h0);
    tick();                                   // T1: r_valid with gnt must be ignored
    penable = 1'b1; gnt = 1'b1; rvalid = 1'b1; rdata = 32'h0BAD_BEEF;
    chk1("o_req", req, 1'b1);
    tick();                                   // T2
    gnt = 1'b0; rvalid = 1'b0;
    chk1("o_req_drop", req, 1'b0);
    for (int i = 0; i < 8; i++) begin         // T2..T9
      chk1("o_wait_pready", pready, 1'b0);
      chk1("o_wait_tmo",    tmo,    1'b0);
      tick();
    end
    chk1 ("o_pready",  pready,  1'b1);        // T10
    chk1 ("o_pslverr", pslverr, 1'b1);
    chk32("o_prdata",  prdata,  ERR);
    chk1 ("o_tmo",     tmo,     1'b1);
    chk1 ("o_busy",    busy,    1'b1);
    psel = 1'b0; penable = 1'b0;
    tick();                                   // T11: IDLE with orphan pending
    chk1("o_busy_idle", busy, 1'b1);
    setup(1'b0, 20'h00200, 32'h0, 4'h0);
    tick();                                   // T12: DRAIN
    penable = 1'b1;
    chk1("d_req_t12",    req,    1'b0);
    chk1("d_pready_t12", pready, 1'b0);
    chk1("d_busy_t12",   busy,   1'b1);
    tick();                                   // T13: late response arrives
    rvalid = 1'b1; rdata = 32'hDEAD_0000;
    chk1("d_req_t13",    req,    1'b0);
    chk1("d_pready_t13", pready, 1'b0);
    tick();                                   // T14: REQ for the new read
    rvalid = 1'b0; gnt = 1'b1;
    chk1 ("d_req",    req,    1'b1);
    chk32("d_add",    add,    32'h0000_0200);
    chk1 ("d_pready", pready, 1'b0);
    chk1 ("d_tmo",    tmo,    1'b0);
    tick();                                   // T15
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1357_9BDF;
    tick();                                   // T16
    rvalid = 1'b0;
    chk1 ("d_pready_done", pready,  1'b1);
    chk32("d_prdata",      prdata,  32'h1357_9BDF);
    chk1 ("d_pslverr",     pslverr, 1'b0);
    psel = 1'b0; penable = 1'b0;
    tick();
    chk1("d_busy_clr", busy, 1'b0);

    // Back-to-back read then write, no idle cycle
    setup(1'b0, 20'h00500, 32'h0, 4'h0);
    tick();                                   // T1
    penable = 1'b1; gnt = 1'b1;
    chk1("b_rd_req", req, 1'b1);
    chk1("b_rd_wen", wen, 1'b1);
    tick();                                   // T2
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h600D_F00D;
    tick();                                   // T3
    rvalid = 1'b0;
    chk1 ("b_rd_pready", pready, 1'b1);
    chk32("b_rd_prdata", prdata, 32'h600D_F00D);
    tick();                                   // T4: next setup immediately
    setup(1'b1, 20'h00504, 32'h8765_4321, 4'hC);
    chk1("b_gap_pready", pready, 1'b0);
    tick();                                   // T5
    penable = 1'b1; gnt = 1'b1;
    chk1 ("b_wr_req",   req,   1'b1);
    chk32("b_wr_add",   add,   32'h0000_0504);
    chk1 ("b_wr_wen",   wen,   1'b0);
    chk32("b_wr_be",    {28'h0, be}, 32'h0000_000C);
    chk32("b_wr_wdata", wdata, 32'h8765_4321);
    tick();                                   // T6
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hFFFF_0000;
    tick();                                   // T7
    rvalid = 1'b0;
    chk1 ("b_wr_pready", pready, 1'b1);
    chk32("b_wr_prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0;
    tick();

    // Asynchronous reset in REQ, then in WAIT
    setup(1'b0, 20'h00300, 32'h0, 4'h0);
    tick();                                   // REQ
    penable = 1'b1;
    chk1("x_req_before", req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("x_req_async", req, 1'b0);
    psel = 1'b0; penable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    setup(1'b1, 20'h00308, 32'h0000_00AA, 4'h1);
    tick();                                   // REQ
    penable = 1'b1; gnt = 1'b1;
    tick();                                   // WAIT
    gnt = 1'b0;
    chk1("x_busy_wait", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1 ("x_req_rst",    req,    1'b0);
    chk1 ("x_pready_rst", pready, 1'b0);
    chk1 ("x_busy_rst",   busy,   1'b0);
    chk1 ("x_wen_rst",    wen,    1'b1);
    chk32("x_be_rst",     {28'h0, be}, 32'h0000_000F);
    psel = 1'b0; penable = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    setup(1'b0, 20'h00304, 32'h0, 4'h0);
    tick();                                   // T1
    penable = 1'b1; gnt = 1'b1;
    chk1 ("x_fresh_req", req, 1'b1);
    chk32("x_fresh_add", add, 32'h0000_0304);
    tick();                                   // T2
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h2468_ACE0;
    tick();                                   // T3
    rvalid = 1'b0;
    chk1 ("x_fresh_pready",  pready,  1'b1);
    chk32("x_fresh_prdata",  prdata,  32'h2468_ACE0);
    chk1 ("x_fresh_pslverr", pslverr, 1'b0);
    psel = 1'b0; penable = 1'b0;
    tick();
    chk1("x_fresh_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/efpga_apb_lint_initiator.md
Name: efpga_apb_lint_initiator

Overview:
- SoC-side initiator that drives the eFPGA LINT (XBAR_TCDM-style req/gnt/r_valid) slave port from an APB slave interface.
- Converts each APB transfer into exactly one LINT request and holds APB (pready low) until r_valid returns.
- Provides a bounded timeout and an error response, so a hung or unconfigured fabric cannot stall the APB bus.
- Sits in the SoC peripheral domain on asic_clk_i, upstream of the eFPGA LINT slave port.

Parameters:
- APB_ADDR_WIDTH, 20, APB address bits forwarded to the LINT address.
- TIMEOUT_CYCLES, 255, number of cycles without gnt (REQ) or r_valid (WAIT) before an error response; must be >= 2.
- ERR_RDATA, 32'hBADACCE5, prdata returned on timeout.

Ports:
- asic_clk_i  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- paddr_i  in  APB_ADDR_WIDTH  APB address
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  APB write (1 = write)
- pwdata_i  in  32  APB write data
- pstrb_i  in  4  APB byte strobes
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- lint_req_o  out  1  LINT request
- lint_gnt_i  in  1  LINT grant
- lint_add_o  out  32  LINT address
- lint_wen_o  out  1  LINT write-enable, active-low (1 = read)
- lint_be_o  out  4  LINT byte enables
- lint_wdata_o  out  32  LINT write data
- lint_r_valid_i  in  1  LINT response valid
- lint_r_rdata_i  in  32  LINT read data
- busy_o  out  1  transaction or orphan drain in progress
- timeout_o  out  1  one-cycle pulse on each timeout

Behaviour:
- Reset values: all outputs 0, except lint_wen_o = 1 and lint_be_o = 4'hF. Reset takes effect asynchronously, including mid-transaction; lint_req_o drops immediately.
- All outputs are registered.
- States are IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE:
  - On psel_i & ~penable_i with orphan = 0, capture the request fields and go to REQ.
  - Captured fields: lint_add_o = {zeros, paddr_i}; lint_wen_o = ~pwrite_i; lint_be_o = pwrite_i ? pstrb_i : 4'hF; lint_wdata_o = pwdata_i.
  - If orphan = 1, go to DRAIN instead; the capture is deferred.
- REQ:
  - lint_req_o = 1; address, wen, be and wdata are held stable.
  - On lint_gnt_i = 1, deassert req next cycle, reload the timeout counter, and go to WAIT.
  - On counter expiry, drop req and go to RESP with error.
- WAIT:
  - Wait for lint_r_valid_i. r_valid is sampled only in this state; an r_valid coinciding with gnt in REQ is a protocol violation and is ignored.
  - On r_valid: prdata_o = lint_r_rdata_i for reads, 0 for writes. Go to RESP, no error.
  - On expiry: set orphan = 1 and go to RESP with error.
- RESP:
  - pready_o = 1 for exactly one cycle; pslverr_o = 1 on the error path; prdata_o = ERR_RDATA on error reads.
  - Then return to IDLE. prdata_o holds its value until the next RESP.
- DRAIN:
  - pready_o stays 0 while waiting for the late r_valid or a fresh TIMEOUT_CYCLES expiry.
  - Either event clears orphan; the late rdata is discarded.
  - Then capture the pending APB setup fields (paddr/pwdata are stable per APB) and go to REQ.
- Minimum latency with gnt same cycle and r_valid next: setup at T0, req at T1, gnt at T1, r_valid at T2, pready at T3.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Loaded with TIMEOUT_CYCLES on entry to REQ, WAIT and DRAIN; decrements each cycle in those states.
  - Expiry fires when the counter reaches 0; it saturates at 0 and never wraps.
- psel_i deasserted mid-transaction (APB violation): the LINT transaction still completes. The pready pulse is still issued in RESP.
- busy_o = (state != IDLE) | orphan.
- timeout_o pulses the cycle the FSM leaves REQ, WAIT or DRAIN on expiry.

Decomposition:
- Package efpga_lint_pkg holds:
  - state enum lint_init_state_e;
  - LINT_WEN_READ = 1'b1;
  - LINT_BE_FULL = 4'hF;
  - the default ERR_RDATA.
- One sub-module, lint_timeout_cnt, with inputs load_i, en_i, load value and expire_o; parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write: APB write paddr=20'h00040, pwdata=32'hA5A5_1234, pstrb=4'h3, gnt immediate, r_valid next cycle -> lint_add_o=32'h40, lint_wen_o=0, lint_be_o=4'h3; pready at T3; pslverr=0.
- Read with gnt delayed 5 cycles and r_valid 3 cycles after gnt, rdata=32'hCAFE_F00D -> req held with stable fields for 6 cycles; prdata=32'hCAFE_F00D, pslverr=0.
- gnt never asserted, TIMEOUT_CYCLES=8 -> req drops after 8 REQ cycles; pready=1, pslverr=1, prdata=32'hBADACCE5; one timeout_o pulse.
- gnt given, r_valid withheld past 8 cycles, then r_valid arrives during a following read -> first read errors; second read waits in DRAIN, discards the late data, then completes with its own rdata.
- rst_n asserted while in WAIT -> lint_req_o=0, pready_o=0, busy_o=0 immediately; a fresh read after release completes normally.
- Back-to-back APB read then write with no idle cycle -> two distinct LINT requests, each with correct wen/be, and two pready pulses.
